ramio_bram: RTL

Memory/IO slave that sits directly downstream of the core and serves its `ramio_*` request interface: byte, half-word and word reads and writes, with optional sign extension. It is backed by an on-chip block RAM, plus two memory-mapped I/O registers: LED output and a UART transmitter. The flash loader in the core and all later core load/store traffic target this block.

---
 rtl/ramio_pkg.sv | 51 +++++
 rtl/ramio_bram_uart_tx.sv | 51 +++++
 rtl/ramio_bram.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/ramio_pkg.sv
// Shared constants, types and lane-extraction helper for the ramio_bram memory/IO slave.
package ramio_pkg;

  localparam logic [1:0] WRITE_NONE = 2'b00;
  localparam logic [1:0] WRITE_BYTE = 2'b01;
  localparam logic [1:0] WRITE_HALF = 2'b10;
  localparam logic [1:0] WRITE_WORD = 2'b11;

  localparam logic [1:0] READ_NONE = 2'b00;
  localparam logic [1:0] READ_BYTE = 2'b01;
  localparam logic [1:0] READ_HALF = 2'b10;
  localparam logic [1:0] READ_WORD = 2'b11;
  localparam int         READ_SIGN_BIT = 2;

  localparam logic [31:0] ADDRESS_LED      = 32'hFFFF_FFFF;
  localparam logic [31:0] ADDRESS_UART_OUT = 32'hFFFF_FFFE;

  typedef logic [0:0] state_t;
  localparam state_t STATE_IDLE = 1'b0;
  localparam state_t STATE_READ = 1'b1;

  typedef enum logic [1:0] {
    TGT_RAM,
    TGT_LED,
    TGT_UART,
    TGT_NONE
  } target_t;

  // Picks the addressed byte/half-word out of a RAM word and extends it to 32 bits.
  function automatic logic [31:0] extract_lane(input logic [31:0] word,
                                               input logic [1:0]  addr_lo,
                                               input logic [2:0]  read_type);
    logic [7:0]  b;
    logic [15:0] h;
    logic        sx;
    case (addr_lo)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h  = addr_lo[1] ? word[31:16] : word[15:0];
    sx = read_type[READ_SIGN_BIT];
    case (read_type[1:0])
      READ_BYTE: return {{24{sx & b[7]}}, b};
      READ_HALF: return {{16{sx & h[15]}}, h};
      default:   return word;
    endcase
  endfunction

endpackage

// File: rtl/ramio_bram_uart_tx.sv
// 8N1 UART transmitter: start bit, 8 data bits LSB first, stop bit; active for 10 bit periods.
module uart_tx #(
  parameter int CLK_FREQ  = 27_000_000,
  parameter int BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       go,
  input  logic [7:0] data,
  output logic       tx,
  output logic       active
);

  localparam int BIT_CYCLES = CLK_FREQ / BAUD_RATE;
  localparam int CW         = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_CYCLE = CW'(BIT_CYCLES - 1);

  logic [9:0]    frame;
  logic [3:0]    bit_idx;
  logic [CW-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      active  <= 1'b0;
      frame   <= '1;
      bit_idx <= '0;
      cnt     <= '0;
    end else if (!active) begin
      if (go) begin
        active  <= 1'b1;
        frame   <= {1'b1, data, 1'b0};
        bit_idx <= '0;
        cnt     <= '0;
      end
    end else if (cnt == LAST_CYCLE) begin
      cnt <= '0;
      if (bit_idx == 4'd9) begin
        active <= 1'b0;
      end else begin
        bit_idx <= bit_idx + 4'd1;
        frame   <= {1'b1, frame[9:1]};
      end
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tx = active ? frame[0] : 1'b1;

endmodule

// File: rtl/ramio_bram.sv
// Memory/IO slave: byte-enable block RAM plus LED and UART registers behind the ramio_* request port.
// Build option: define RAMIO_UART_EN to instantiate the UART at ADDRESS_UART_OUT.
module ramio_bram
  import ramio_pkg::*;
#(
  parameter int RAM_ADDR_WIDTH = 12,
  parameter int CLK_FREQ       = 27_000_000,
  parameter int BAUD_RATE      = 115200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [1:0]  write_type,
  input  logic [2:0]  read_type,
  input  logic [31:0] address,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        data_out_ready,
  output logic        busy,
  output logic [3:0]  led,
  output logic        uart_tx
);

  localparam logic [31:0] RAM_BYTES = 32'(4) << RAM_ADDR_WIDTH;

  logic [31:0] mem [0:(2**RAM_ADDR_WIDTH)-1];
  logic [31:0] ram_q;

  state_t      state;
  logic        served;
  logic        uart_active;
  logic        accept;
  logic        is_write;
  logic        is_read;
  target_t     tgt;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] io_word;

  target_t     rd_tgt;
  logic [2:0]  rd_type;
  logic [1:0]  rd_lo;
  logic [31:0] rd_io;

  logic [RAM_ADDR_WIDTH-1:0] word_addr;
  assign word_addr = address[RAM_ADDR_WIDTH+1:2];

  assign busy     = (state == STATE_READ) || uart_active;
  assign accept   = enable && !served && !busy;
  assign is_write = accept && (write_type != WRITE_NONE);
  assign is_read  = accept && (write_type == WRITE_NONE) && (read_type[1:0] != READ_NONE);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    tgt = TGT_NONE;
    if (address < RAM_BYTES)
      tgt = TGT_RAM;
    else if (address == ADDRESS_LED)
      tgt = TGT_LED;
`ifdef RAMIO_UART_EN
    else if (address == ADDRESS_UART_OUT)
      tgt = TGT_UART;
`endif
  end

  // Right-aligned write data is replicated across lanes; byte enables pick the target lane.
  always_comb begin
    be    = 4'b0000;
    wdata = data_in;
    case (write_type)
      WRITE_BYTE: begin
        be    = 4'b0001 << address[1:0];
        wdata = {4{data_in[7:0]}};
      end
      WRITE_HALF: begin
        be    = address[1] ? 4'b1100 : 4'b0011;
        wdata = {2{data_in[15:0]}};
      end
      WRITE_WORD: be = 4'b1111;
      default:    be = 4'b0000;
    endcase
  end

  always_comb begin
    io_word = 32'd0;
    case (tgt)
      TGT_LED:  io_word = {28'd0, led};
      TGT_UART: io_word = {31'd0, uart_active};
      default:  io_word = 32'd0;
    endcase
  end

  // NOTE: the RAM array has no reset; contents survive rst_n and map onto block RAM.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (is_write && tgt == TGT_RAM && be[b])
        mem[word_addr][8*b +: 8] <= wdata[8*b +: 8];
    end
    if (is_read)
      ram_q <= mem[word_addr];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= STATE_IDLE;
      served         <= 1'b0;
      data_out       <= '0;
      data_out_ready <= 1'b0;
      led            <= 4'b1111;
      rd_tgt         <= TGT_NONE;
      rd_type        <= '0;
      rd_lo          <= '0;
      rd_io          <= '0;
    end else begin
      served <= enable && (served || accept);
      if (accept)
        data_out_ready <= 1'b0;
      if (is_write && tgt == TGT_LED)
        led <= data_in[3:0];
      case (state)
        STATE_IDLE: begin
          if (is_read) begin
            state   <= STATE_READ;
            rd_tgt  <= tgt;
            rd_type <= read_type;
            rd_lo   <= address[1:0];
            rd_io   <= io_word;
          end
        end
        default: begin
          state          <= STATE_IDLE;
          data_out_ready <= 1'b1;
          data_out       <= (rd_tgt == TGT_RAM) ? extract_lane(ram_q, rd_lo, rd_type) : rd_io;
        end
      endcase
    end
  end

`ifdef RAMIO_UART_EN
  logic uart_go;
  assign uart_go = is_write && tgt == TGT_UART;

  uart_tx #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD_RATE(BAUD_RATE)
  ) u_uart_tx (
    .clk   (clk),
    .rst_n (rst_n),
    .go    (uart_go),
    .data  (data_in[7:0]),
    .tx    (uart_tx),
    .active(uart_active)
  );
`else
  assign uart_tx     = 1'b1;
  assign uart_active = 1'b0;
`endif

endmodule
